// File: rtl/mcp320x_scan_master.sv
// SPI master for the MCP3202 dual-channel 12-bit ADC. It scans the enabled channels
// round-robin, one bit-counted frame per sample period, and emits a channel-tagged result pulse.
module mcp320x_scan_master #(
  parameter int SCK_HALF_DIV  = 88,
  parameter int SAMPLE_PERIOD = 3117,
  parameter int TCSH_CYCLES   = 125,
  parameter int DATA_W        = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        ch_mask,
  input  logic              diff_mode,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic              CS,
  output logic [DATA_W-1:0] o_DATA,
  output logic              o_CH,
  output logic              DATA_VALID,
  output logic              busy
);

  localparam int TMR_MAX   = (SCK_HALF_DIV > TCSH_CYCLES) ? SCK_HALF_DIV : TCSH_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int CNT_W     = $clog2(SAMPLE_PERIOD + 1);
  localparam int LAST_HALF = 33;

  if (DATA_W != 12) begin : g_bad_width
    $error("mcp320x_scan_master: DATA_W must be 12");
  end
  if (SCK_HALF_DIV < 1) begin : g_bad_div
    $error("mcp320x_scan_master: SCK_HALF_DIV must be >= 1");
  end
  if (SAMPLE_PERIOD < 36 * SCK_HALF_DIV + TCSH_CYCLES + 1) begin : g_bad_period
    $error("mcp320x_scan_master: SAMPLE_PERIOD too short for one frame plus CS-high time");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [5:0]        half_q, half_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              sgl_q, sgl_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
  logic              och_q, och_d, dv_q, dv_d, busy_q, busy_d;
  logic              trig, half_end, nxt_ch, sample;

  assign trig     = en && (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
  assign half_end = (tmr_q == TMR_W'(SCK_HALF_DIV - 1));
  assign nxt_ch   = ch_mask[~ptr_q] ? ~ptr_q : ptr_q;
  // SHIFT halves alternate low/high; odd halves 11..33 are the high halves of data edges 6..17
  assign sample   = (state_q == S_SHIFT) && half_q[0] && (tmr_q == '0) && (half_q >= 6'd11);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      half_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      data_q  <= '0;
      och_q   <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      data_q  <= data_d;
      och_q   <= och_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    sgl_q   <= sgl_d;
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TMR_W'(1);
    half_d  = half_q;
    ptr_d   = ptr_q;
    sgl_d   = sgl_q;
    cnt_d   = (!en || trig) ? '0 : cnt_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (trig && (ch_mask != 2'b00)) begin
          state_d = S_LEAD;
          ptr_d   = nxt_ch;
          sgl_d   = ~diff_mode;
        end
      end
      S_LEAD: if (half_end) begin
        state_d = S_SHIFT;
        tmr_d   = '0;
        half_d  = '0;
      end
      S_SHIFT: if (half_end) begin
        tmr_d = '0;
        if (half_q == 6'(LAST_HALF)) state_d = S_TRAIL;
        else half_d = half_q + 6'd1;
      end
      S_TRAIL: if (half_end) begin
        state_d = S_HOLD;
        tmr_d   = '0;
      end
      S_HOLD: if (tmr_q == TMR_W'(TCSH_CYCLES - 1)) begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin outputs are registered copies of what the next state dictates
  always_comb begin
    cs_d   = !(state_d inside {S_LEAD, S_SHIFT, S_TRAIL});
    sck_d  = (state_d == S_SHIFT) && half_d[0];
    busy_d = (state_d != S_IDLE);
    mosi_d = 1'b0;
    case (state_d)
      S_LEAD:  mosi_d = 1'b1;
      S_SHIFT: begin
        case (half_d[5:1])
          5'd1:    mosi_d = sgl_d;
          5'd2:    mosi_d = ptr_d;
          default: mosi_d = 1'b1;
        endcase
      end
      S_TRAIL: mosi_d = 1'b1;
      default: mosi_d = 1'b0;
    endcase
    dv_d    = (state_q == S_TRAIL) && half_end;
    data_d  = dv_d ? shreg_q : data_q;
    och_d   = dv_d ? ptr_q : och_q;
    shreg_d = sample ? {shreg_q[DATA_W-2:0], MISO} : shreg_q;
  end

  assign MOSI       = mosi_q;
  assign SCK        = sck_q;
  assign CS         = cs_q;
  assign o_DATA     = data_q;
  assign o_CH       = och_q;
  assign DATA_VALID = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mcp320x_scan_master.sv
// Bench for mcp320x_scan_master: an MCP3202 pin model plus a frame-position reference model,
// directed scenarios followed by randomized segments.
module tb_mcp320x_scan_master;

  localparam int H    = 2;
  localparam int SP   = 100;
  localparam int TCSH = 4;
  localparam int FL   = 36 * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  ch_mask = 2'b00;
  logic        diff_mode = 1'b0;
  logic        MISO = 1'b0;
  logic        MOSI, SCK, CS;
  logic [11:0] o_DATA;
  logic        o_CH, DATA_VALID, busy;

  always #5 clk = ~clk;

  mcp320x_scan_master #(
    .SCK_HALF_DIV (H),
    .SAMPLE_PERIOD(SP),
    .TCSH_CYCLES  (TCSH),
    .DATA_W       (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ch_mask   (ch_mask),
    .diff_mode (diff_mode),
    .MISO      (MISO),
    .MOSI      (MOSI),
    .SCK       (SCK),
    .CS        (CS),
    .o_DATA    (o_DATA),
    .o_CH      (o_CH),
    .DATA_VALID(DATA_VALID),
    .busy      (busy)
  );

  // Conversion table indexed by {SGL, ODD}
  logic [11:0] tbl [4];

  int n_chk = 0;
  int n_err = 0;

  // Reference model: where we are within a frame, counted in clk cycles from CS fall
  int          m_cnt = 0;
  int          m_pos = -1;
  logic        m_last = 1'b0, m_ch = 1'b0, m_sgl = 1'b0, m_och = 1'b0;
  logic [11:0] m_data = '0, m_exp = '0;

  always @(posedge clk) begin : ref_model
    logic trig;
    logic found;
    logic pick;
    if (rst) begin
      m_cnt = 0; m_pos = -1; m_last = 1'b0; m_data = '0; m_och = 1'b0;
    end else begin
      trig = en && (m_cnt == SP - 1);
      if (!en || trig) m_cnt = 0;
      else m_cnt++;
      if (m_pos < 0) begin
        if (trig && ch_mask != 2'b00) begin
          found = 1'b0;
          pick  = m_last;
          for (int k = 1; k <= 2; k++) begin
            if (!found && ch_mask[(int'(m_last) + k) % 2]) begin
              pick  = 1'((int'(m_last) + k) % 2);
              found = 1'b1;
            end
          end
          m_ch   = pick;
          m_last = pick;
          m_sgl  = ~diff_mode;
          m_exp  = tbl[{m_sgl, m_ch}];
          m_pos  = 0;
        end
      end else begin
        m_pos++;
        if (m_pos == FL) begin
          m_data = m_exp;
          m_och  = m_ch;
        end
        if (m_pos == FL + TCSH) m_pos = -1;
      end
    end
  end

  // ADC pin model and frame monitor, sampled 2 time units after each rising clk edge
  logic        prev_cs = 1'b1, prev_sck = 1'b0;
  int          bitn = 0, rises = 0, lowlen = 0, last_rises = 0, last_len = 0;
  int          n_falls = 0, fall_cyc = 0, fall_prev = 0, n_dv = 0, cyc = 0;
  logic [3:0]  cmd = '0, last_cmd = '0;
  logic [11:0] conv = '0;
  logic [11:0] snap [4];

  always @(posedge clk) begin : adc_mon
    #2;
    cyc++;
    if (prev_cs && !CS) begin
      bitn = 0; cmd = '0; rises = 0; lowlen = 0;
      for (int i = 0; i < 4; i++) snap[i] = tbl[i];
      n_falls++;
      fall_prev = fall_cyc;
      fall_cyc  = cyc;
    end
    if (!CS) lowlen++;
    if (!prev_sck && SCK && !CS) begin
      rises++;
      bitn++;
      if (bitn <= 4) cmd[4 - bitn] = MOSI;
      if (bitn == 5) conv = snap[{cmd[2], cmd[1]}];
      if (bitn >= 6 && bitn <= 17) MISO = conv[17 - bitn];
    end
    // Data is only valid while SCK is high; scramble it during the low half
    if (prev_sck && !SCK && !CS && bitn >= 6) MISO = ~MISO;
    if (!prev_cs && CS) begin
      last_rises = rises;
      last_len   = lowlen;
      last_cmd   = cmd;
    end
    if (DATA_VALID) n_dv++;
    prev_cs  = CS;
    prev_sck = SCK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_all();
    int   p, h, edge_n;
    logic e_cs, e_sck, e_mosi, e_busy, e_dv;
    p      = m_pos;
    e_busy = (p >= 0);
    e_cs   = !(p >= 0 && p < FL);
    e_dv   = (p == FL);
    e_sck  = 1'b0;
    e_mosi = 1'b0;
    if (p >= 0 && p < H) e_mosi = 1'b1;
    else if (p >= H && p < 35 * H) begin
      h      = (p - H) / H;
      e_sck  = (h % 2) == 1;
      edge_n = h / 2 + 1;
      e_mosi = (edge_n == 2) ? m_sgl : (edge_n == 3) ? m_ch : 1'b1;
    end else if (p >= 35 * H && p < FL) e_mosi = 1'b1;
    chk("CS", 32'(CS), 32'(e_cs));
    chk("SCK", 32'(SCK), 32'(e_sck));
    chk("MOSI", 32'(MOSI), 32'(e_mosi));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("DATA_VALID", 32'(DATA_VALID), 32'(e_dv));
    chk("o_DATA", 32'(o_DATA), 32'(m_data));
    chk("o_CH", 32'(o_CH), 32'(m_och));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_all();
    end
  endtask

  task automatic wait_dv(input int bound);
    logic got;
    got = 1'b0;
    for (int n = 0; n < bound && !got; n++) begin
      step(1);
      if (DATA_VALID === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL wait_dv: no DATA_VALID within %0d cycles", bound);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int bound);
    logic got;
    got = (busy === lvl);
    for (int n = 0; n < bound && !got; n++) begin
      step(1);
      if (busy === lvl) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL wait_busy: busy never reached %0d within %0d cycles", lvl, bound);
    end
  endtask

  task automatic wait_rises(input int target, input int bound);
    logic got;
    got = (rises >= target);
    for (int n = 0; n < bound && !got; n++) begin
      step(1);
      if (rises >= target) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL wait_rises: SCK edge %0d not reached within %0d cycles", target, bound);
    end
  endtask

  initial begin
    int          f0, d0, n;
    logic [11:0] e0;
    logic        got;
    for (int i = 0; i < 4; i++) tbl[i] = '0;

    // Reset state
    step(3);
    chk("rst_CS", 32'(CS), 32'h1);
    chk("rst_SCK", 32'(SCK), 32'h0);
    chk("rst_MOSI", 32'(MOSI), 32'h0);
    chk("rst_o_DATA", 32'(o_DATA), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single channel, single-ended
    tbl[2]    = 12'hA5C;
    ch_mask   = 2'b01;
    diff_mode = 1'b0;
    en        = 1'b1;
    wait_dv(300);
    chk("single_cmd", 32'(last_cmd), 32'hD);
    chk("single_rises", 32'(last_rises), 32'd17);
    chk("single_cs_low", 32'(last_len), 32'd72);
    chk("single_data", 32'(o_DATA), 32'hA5C);
    chk("single_ch", 32'(o_CH), 32'h0);
    step(1);
    chk("single_dv_width", 32'(DATA_VALID), 32'h0);
    wait_dv(300);
    chk("frame_interval", 32'(fall_cyc - fall_prev), 32'd100);

    // Round robin over both channels
    tbl[2]  = 12'h001;
    tbl[3]  = 12'hFFF;
    ch_mask = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_dv(300);
      chk("rr_ch", 32'(o_CH), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_data", 32'(o_DATA), (i % 2 == 0) ? 32'hFFF : 32'h001);
      chk("rr_odd", 32'(last_cmd[1]), (i % 2 == 0) ? 32'h1 : 32'h0);
    end

    // Mode and mask change in the middle of a frame
    wait_busy(1'b0, 300);
    wait_busy(1'b1, 300);
    step(20);
    e0 = tbl[2];
    for (int i = 0; i < 4; i++) tbl[i] = 12'($urandom);
    diff_mode = 1'b1;
    ch_mask   = 2'b10;
    wait_dv(300);
    chk("midchg_ch", 32'(o_CH), 32'h0);
    chk("midchg_data", 32'(o_DATA), 32'(e0));
    chk("midchg_cmd", 32'(last_cmd), 32'hD);
    wait_dv(300);
    chk("diff_ch", 32'(o_CH), 32'h1);
    chk("diff_data", 32'(o_DATA), 32'(tbl[1]));
    chk("diff_cmd", 32'(last_cmd), 32'hB);

    // Empty mask
    ch_mask = 2'b00;
    d0 = n_dv;
    f0 = n_falls;
    step(300);
    chk("empty_dv", 32'(n_dv - d0), 32'h0);
    chk("empty_cs", 32'(n_falls - f0), 32'h0);

    // en dropped mid-frame
    ch_mask   = 2'b01;
    diff_mode = 1'b0;
    wait_busy(1'b1, 300);
    wait_rises(8, 300);
    en = 1'b0;
    f0 = n_falls;
    wait_dv(200);
    chk("endrop_ch", 32'(o_CH), 32'h0);
    chk("endrop_data", 32'(o_DATA), 32'(tbl[2]));
    step(250);
    chk("endrop_no_frame", 32'(n_falls - f0), 32'h0);
    chk("endrop_cs", 32'(CS), 32'h1);

    // Reset in the middle of a frame
    en = 1'b1;
    wait_busy(1'b1, 300);
    wait_rises(10, 300);
    rst = 1'b1;
    step(1);
    chk("midrst_CS", 32'(CS), 32'h1);
    chk("midrst_SCK", 32'(SCK), 32'h0);
    chk("midrst_MOSI", 32'(MOSI), 32'h0);
    chk("midrst_o_DATA", 32'(o_DATA), 32'h0);
    chk("midrst_dv", 32'(DATA_VALID), 32'h0);
    rst = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < 300 && !got) begin
      step(1);
      n++;
      if (CS === 1'b0) got = 1'b1;
    end
    chk("restart_delay", 32'(n), 32'd100);

    // Randomized segments
    for (int s = 0; s < 25; s++) begin
      ch_mask   = 2'($urandom_range(0, 3));
      diff_mode = 1'($urandom_range(0, 1));
      en        = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 4; i++) tbl[i] = 12'($urandom);
      step($urandom_range(40, 250));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
    end
    step(100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
